// File: rtl/posit4_acc_seq_if.sv
// Handshake and data bundle between the posit4 job sequencer, its term source,
// the fixed-point accumulator and the re-encode stage that takes the result.
interface posit4_acc_seq_if #(
  parameter int LEN_W = 8
);
  // job request
  logic             job_start;
  logic [LEN_W-1:0] job_len;
  logic [4:0]       job_exp_set;
  logic             job_busy;

  // decoded product-term stream
  logic             term_valid;
  logic             term_ready;
  logic             term_sign;
  logic [4:0]       term_exp;
  logic [13:0]      term_fixed;
  logic             term_zero;
  logic             term_nar;

  // accumulator command / response
  logic             acc_start;
  logic             acc_sign;
  logic [4:0]       acc_exp_set;
  logic [4:0]       acc_exp_in;
  logic [13:0]      acc_fixed_in;
  logic [31:0]      acc_fixed_acc;
  logic             acc_zero;
  logic             acc_nar;
  logic             acc_done;
  logic [31:0]      acc_fixed_out;

  // job result
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_fixed;
  logic [4:0]       res_exp;
  logic             res_nar;
  logic             res_timeout;

  // Environment side: issues jobs and terms, models the accumulator, takes results.
  modport master (
    output job_start, job_len, job_exp_set,
    input  job_busy,
    output term_valid, term_sign, term_exp, term_fixed, term_zero, term_nar,
    input  term_ready,
    input  acc_start, acc_sign, acc_exp_set, acc_exp_in, acc_fixed_in,
    input  acc_fixed_acc, acc_zero, acc_nar,
    output acc_done, acc_fixed_out,
    input  res_valid, res_fixed, res_exp, res_nar, res_timeout,
    output res_ready
  );

  // Sequencer side.
  modport slave (
    input  job_start, job_len, job_exp_set,
    output job_busy,
    input  term_valid, term_sign, term_exp, term_fixed, term_zero, term_nar,
    output term_ready,
    output acc_start, acc_sign, acc_exp_set, acc_exp_in, acc_fixed_in,
    output acc_fixed_acc, acc_zero, acc_nar,
    input  acc_done, acc_fixed_out,
    output res_valid, res_fixed, res_exp, res_nar, res_timeout,
    input  res_ready
  );
endinterface

// File: rtl/posit4_acc_seq.sv
// Job-level sequencer for the posit4 accumulator: pulls product terms, issues one
// accumulate per non-trivial term, feeds the running sum back and returns the result.
module posit4_acc_seq #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  posit4_acc_seq_if.slave bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t state_q, state_d;

  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [4:0]        exp_set_q;
  logic [31:0]       sum_q;
  logic              nar_q;
  logic              timeout_q;
  logic [WAIT_W-1:0] wait_q;
  logic              acc_sign_q;
  logic [4:0]        acc_exp_q;
  logic [13:0]       acc_fixed_q;

  // control strobes decoded from the current state and inputs
  logic job_accept;
  logic term_skip;
  logic term_take;
  logic wait_done;
  logic wait_expire;
  logic cnt_last;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    job_accept  = 1'b0;
    term_skip   = 1'b0;
    term_take   = 1'b0;
    wait_done   = 1'b0;
    wait_expire = 1'b0;
    cnt_last    = ((cnt_q + LEN_W'(1)) == len_q);

    case (state_q)
      S_IDLE: begin
        if (bus.job_start) begin
          job_accept = 1'b1;
          state_d    = (bus.job_len == '0) ? S_RESULT : S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.term_valid) begin
          if (bus.term_nar || bus.term_zero) begin
            term_skip = 1'b1;
            state_d   = cnt_last ? S_RESULT : S_FETCH;
          end else begin
            term_take = 1'b1;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The first WAIT cycle still sees the previous term's done level.
        if ((wait_q != '0) && bus.acc_done) begin
          wait_done = 1'b1;
          state_d   = cnt_last ? S_RESULT : S_FETCH;
        end else if (wait_q == WAIT_W'(TIMEOUT)) begin
          wait_expire = 1'b1;
          state_d     = S_RESULT;
        end
      end
      S_RESULT: begin
        if (bus.res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: the asynchronous reset clears every register, so all outputs read zero during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      cnt_q       <= '0;
      exp_set_q   <= '0;
      sum_q       <= '0;
      nar_q       <= 1'b0;
      timeout_q   <= 1'b0;
      wait_q      <= '0;
      acc_sign_q  <= 1'b0;
      acc_exp_q   <= '0;
      acc_fixed_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (job_accept) begin
        len_q     <= bus.job_len;
        exp_set_q <= bus.job_exp_set;
        sum_q     <= '0;
        cnt_q     <= '0;
        nar_q     <= 1'b0;
        timeout_q <= 1'b0;
      end

      // Zero and NaR terms are consumed in place so the stream stays aligned.
      if (term_skip) begin
        cnt_q <= cnt_q + LEN_W'(1);
        if (bus.term_nar) begin
          nar_q <= 1'b1;
        end
      end

      if (term_take) begin
        acc_sign_q  <= bus.term_sign;
        acc_exp_q   <= bus.term_exp;
        acc_fixed_q <= bus.term_fixed;
      end

      if (state_q == S_ISSUE) begin
        wait_q <= '0;
      end else if (state_q == S_WAIT) begin
        wait_q <= wait_q + WAIT_W'(1);
      end

      // The sum is only ever loaded from the accumulator result.
      if (wait_done) begin
        sum_q <= bus.acc_fixed_out;
        cnt_q <= cnt_q + LEN_W'(1);
      end

      if (wait_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.job_busy      = (state_q != S_IDLE);
  assign bus.term_ready    = (state_q == S_FETCH);

  assign bus.acc_start     = (state_q == S_ISSUE);
  assign bus.acc_sign      = acc_sign_q;
  assign bus.acc_exp_set   = exp_set_q;
  assign bus.acc_exp_in    = acc_exp_q;
  assign bus.acc_fixed_in  = acc_fixed_q;
  assign bus.acc_fixed_acc = sum_q;
  assign bus.acc_zero      = 1'b0;
  assign bus.acc_nar       = 1'b0;

  assign bus.res_valid     = (state_q == S_RESULT);
  assign bus.res_fixed     = sum_q;
  assign bus.res_exp       = exp_set_q;
  assign bus.res_nar       = nar_q;
  assign bus.res_timeout   = timeout_q;

endmodule

// File: tb/tb_posit4_acc_seq.sv
// Self-checking bench for posit4_acc_seq: directed vector table, timeout and
// mid-job reset sequences, then random jobs against a term-list reference model.
module tb_posit4_acc_seq;

  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 15;
  localparam int BOUND   = 400;

  typedef struct packed {
    logic        sign;
    logic [4:0]  exp;
    logic [13:0] fixed;
    logic        zero;
    logic        nar;
  } term_t;

  typedef struct {
    int          len;
    logic [4:0]  es;
    term_t [3:0] t;
    logic [31:0] e_fixed;
    logic        e_nar;
    int          e_starts;
    int          e_lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] fixed;
    logic [4:0]  exp;
    logic        nar;
    logic        to;
    int          starts;
    int          readies;
    int          lat;
    bit          got;
  } obs_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  term_t tq[$];
  bit   hang;
  int   pend;
  logic [31:0] pend_val;

  posit4_acc_seq_if #(.LEN_W(LEN_W)) bus ();

  posit4_acc_seq #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic term_t mk(input logic sign, input logic [4:0] e, input logic [13:0] f,
                               input logic zero, input logic nar);
    term_t t;
    t.sign = sign; t.exp = e; t.fixed = f; t.zero = zero; t.nar = nar;
    return t;
  endfunction

  // Value a term contributes: magnitude aligned to the block exponent, then signed.
  function automatic logic [31:0] term_val(input logic sign, input logic [4:0] e,
                                           input logic [13:0] f, input logic [4:0] es);
    logic [31:0] m;
    logic [31:0] v;
    int d;
    m = {18'd0, f};
    d = int'(e) - int'(es);
    if (d >= 0) v = m << d;
    else        v = m >> (-d);
    return sign ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] ref_sum(input logic [4:0] es);
    logic [31:0] s;
    s = '0;
    foreach (tq[i]) if (!tq[i].zero && !tq[i].nar) s = s + term_val(tq[i].sign, tq[i].exp, tq[i].fixed, es);
    return s;
  endfunction

  function automatic int ref_starts();
    int n;
    n = 0;
    foreach (tq[i]) if (!tq[i].zero && !tq[i].nar) n++;
    return n;
  endfunction

  function automatic logic ref_nar();
    logic r;
    r = 1'b0;
    foreach (tq[i]) r = r | tq[i].nar;
    return r;
  endfunction

  function automatic logic any_out();
    return |{bus.job_busy, bus.term_ready, bus.acc_start, bus.acc_sign, bus.acc_exp_set,
             bus.acc_exp_in, bus.acc_fixed_in, bus.acc_fixed_acc, bus.acc_zero, bus.acc_nar,
             bus.res_valid, bus.res_fixed, bus.res_exp, bus.res_nar, bus.res_timeout};
  endfunction

  // Accumulator model: done level rises two cycles after start with operand + aligned term;
  // between terms it keeps the stale done level. In hang mode done drops and never returns.
  always @(negedge clk) begin
    if (rst) begin
      bus.acc_done      = 1'b0;
      bus.acc_fixed_out = '0;
      pend              = 0;
    end else if (bus.acc_start) begin
      pend_val = bus.acc_fixed_acc + term_val(bus.acc_sign, bus.acc_exp_in, bus.acc_fixed_in, bus.acc_exp_set);
      if (hang) begin
        bus.acc_done = 1'b0;
        pend         = 0;
      end else begin
        pend = 2;
      end
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.acc_done      = 1'b1;
        bus.acc_fixed_out = pend_val;
      end
    end
  end

  task automatic run_job(input int len, input logic [4:0] es, input bit bubbles,
                         input int hold, output obs_t o);
    int idx, cyc, hs0, last;
    logic [31:0] run;
    bit stable;
    idx = 0; cyc = 0; hs0 = -1; last = -1; run = '0; stable = 1'b1;
    o.fixed = '0; o.exp = '0; o.nar = 1'b0; o.to = 1'b0;
    o.starts = 0; o.readies = 0; o.lat = 0; o.got = 1'b0;

    @(negedge clk);
    bus.job_start   = 1'b1;
    bus.job_len     = LEN_W'(len);
    bus.job_exp_set = es;

    while (!o.got && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      bus.job_start = 1'b0;
      if (bus.acc_start) begin
        o.starts++;
        if (last >= 0) begin
          check("acc_operands",
                32'({bus.acc_zero, bus.acc_nar, bus.acc_sign, bus.acc_exp_in, bus.acc_fixed_in, bus.acc_exp_set}),
                32'({2'b00, tq[last].sign, tq[last].exp, tq[last].fixed, es}));
          check("acc_fixed_acc", bus.acc_fixed_acc, run);
          run = run + term_val(tq[last].sign, tq[last].exp, tq[last].fixed, es);
        end
      end
      if (bus.res_valid) begin
        o.got   = 1'b1;
        o.fixed = bus.res_fixed;
        o.exp   = bus.res_exp;
        o.nar   = bus.res_nar;
        o.to    = bus.res_timeout;
      end else begin
        if (bus.term_ready) o.readies++;
        if (idx < tq.size()) begin
          bus.term_valid = !bubbles || ($urandom_range(3) != 0);
          bus.term_sign  = tq[idx].sign;
          bus.term_exp   = tq[idx].exp;
          bus.term_fixed = tq[idx].fixed;
          bus.term_zero  = tq[idx].zero;
          bus.term_nar   = tq[idx].nar;
        end else begin
          bus.term_valid = 1'b0;
        end
        if (bus.term_ready && bus.term_valid) begin
          if (hs0 < 0) hs0 = cyc;
          last = idx;
          idx++;
        end
      end
    end
    bus.term_valid = 1'b0;
    o.lat = (hs0 >= 0) ? (cyc - hs0) : cyc;

    if (!o.got) begin
      check("job_bound", 32'd0, 32'd1);
      return;
    end

    for (int h = 0; h < hold; h++) begin
      bus.job_start = (h == 1);
      @(negedge clk);
      if (!bus.res_valid || bus.res_fixed !== o.fixed || bus.res_exp !== o.exp ||
          bus.res_nar !== o.nar || bus.res_timeout !== o.to) stable = 1'b0;
    end
    if (hold > 0) check("res_hold_stable", 32'(stable), 32'd1);

    bus.res_ready = 1'b1;
    bus.job_start = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.job_start = 1'b0;
    check("idle_after_res", 32'({bus.job_busy, bus.res_valid, bus.term_ready}), 32'd0);
  endtask

  vec_t vt[6];
  obs_t o;

  initial begin
    rst = 1'b1; hang = 1'b0;
    bus.job_start = 1'b0; bus.job_len = '0; bus.job_exp_set = '0;
    bus.term_valid = 1'b0; bus.term_sign = 1'b0; bus.term_exp = '0;
    bus.term_fixed = '0; bus.term_zero = 1'b0; bus.term_nar = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs_zero", 32'(any_out()), 32'd0);
    rst = 1'b0;

    // len, exp_set, terms, expected sum, nar, starts, latency from first handshake, hold
    vt[0] = '{2, 5'd3, {term_t'(0), term_t'(0), mk(1, 5'd3, 14'h0040, 0, 0), mk(0, 5'd5, 14'h0100, 0, 0)},
              32'h0000_03C0, 1'b0, 2, 8, 5};
    vt[1] = '{3, 5'd2, {term_t'(0), mk(0, 5'd4, 14'h0020, 0, 0), mk(0, 5'd9, 14'h1234, 1, 0), mk(0, 5'd3, 14'h0010, 0, 0)},
              32'h0000_00A0, 1'b0, 2, 9, 1};
    vt[2] = '{3, 5'd2, {term_t'(0), mk(0, 5'd2, 14'h0003, 0, 0), mk(0, 5'd2, 14'h0055, 0, 1), mk(1, 5'd2, 14'h0100, 0, 0)},
              32'hFFFF_FF03, 1'b1, 2, 9, 0};
    vt[3] = '{0, 5'd7, {term_t'(0), term_t'(0), term_t'(0), term_t'(0)},
              32'h0000_0000, 1'b0, 0, 1, 2};
    vt[4] = '{1, 5'd4, {term_t'(0), term_t'(0), term_t'(0), mk(0, 5'd1, 14'h3FFF, 0, 0)},
              32'h0000_07FF, 1'b0, 1, 4, 0};
    vt[5] = '{2, 5'd9, {term_t'(0), term_t'(0), mk(0, 5'd0, 14'h0055, 1, 1), mk(0, 5'd7, 14'h0123, 1, 0)},
              32'h0000_0000, 1'b1, 0, 2, 0};

    for (int v = 0; v < 6; v++) begin
      tq.delete();
      for (int i = 0; i < vt[v].len; i++) tq.push_back(vt[v].t[i]);
      run_job(vt[v].len, vt[v].es, 1'b0, vt[v].hold, o);
      check($sformatf("v%0d_res_fixed", v), o.fixed, vt[v].e_fixed);
      check($sformatf("v%0d_res_exp", v), 32'(o.exp), 32'(vt[v].es));
      check($sformatf("v%0d_res_nar", v), 32'(o.nar), 32'(vt[v].e_nar));
      check($sformatf("v%0d_res_timeout", v), 32'(o.to), 32'd0);
      check($sformatf("v%0d_acc_starts", v), 32'(o.starts), 32'(vt[v].e_starts));
      check($sformatf("v%0d_latency", v), 32'(o.lat), 32'(vt[v].e_lat));
      check($sformatf("v%0d_term_ready_cycles", v), 32'(o.readies), 32'(vt[v].len));
    end

    // Accumulator never answers: job aborts after TIMEOUT+1 WAIT cycles with the sum untouched.
    hang = 1'b1;
    tq.delete();
    tq.push_back(mk(0, 5'd6, 14'h0200, 0, 0));
    tq.push_back(mk(0, 5'd6, 14'h0001, 0, 0));
    run_job(2, 5'd6, 1'b0, 0, o);
    check("to_res_timeout", 32'(o.to), 32'd1);
    check("to_res_fixed", o.fixed, 32'd0);
    check("to_acc_starts", 32'(o.starts), 32'd1);
    check("to_latency", 32'(o.lat), 32'(TIMEOUT + 3));
    hang = 1'b0;

    // Reset pulsed during WAIT clears everything at once; a fresh job then runs normally.
    begin
      int c;
      bit seen;
      c = 0; seen = 1'b0;
      @(negedge clk);
      bus.job_start = 1'b1; bus.job_len = LEN_W'(1); bus.job_exp_set = 5'd4;
      bus.term_valid = 1'b1; bus.term_sign = 1'b0; bus.term_exp = 5'd4;
      bus.term_fixed = 14'h0100; bus.term_zero = 1'b0; bus.term_nar = 1'b0;
      while (!seen && c < 20) begin
        @(negedge clk);
        c++;
        bus.job_start = 1'b0;
        if (bus.acc_start) seen = 1'b1;
      end
      bus.term_valid = 1'b0;
      check("rst_reached_issue", 32'(seen), 32'd1);
      @(negedge clk);
      check("rst_pre_busy", 32'({bus.job_busy, bus.acc_fixed_in}), 32'({1'b1, 14'h0100}));
      #1 rst = 1'b1;
      #1 check("rst_async_clear", 32'(any_out()), 32'd0);
      @(negedge clk);
      rst = 1'b0;
    end
    tq.delete();
    for (int i = 0; i < vt[0].len; i++) tq.push_back(vt[0].t[i]);
    run_job(vt[0].len, vt[0].es, 1'b0, 0, o);
    check("post_rst_res_fixed", o.fixed, vt[0].e_fixed);
    check("post_rst_acc_starts", 32'(o.starts), 32'(vt[0].e_starts));

    // Random jobs with stream bubbles against the term-list model.
    for (int j = 0; j < 24; j++) begin
      int len;
      logic [4:0] es;
      len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 6));
      es  = 5'($urandom_range(4, 12));
      tq.delete();
      for (int i = 0; i < len; i++) begin
        int r;
        r = int'($urandom_range(99));
        tq.push_back(mk(1'($urandom), 5'(int'(es) - 4 + int'($urandom_range(14))),
                        14'($urandom), r < 20, r >= 12 && r < 25));
      end
      run_job(len, es, 1'b1, int'($urandom_range(3)), o);
      check($sformatf("r%0d_res_fixed", j), o.fixed, ref_sum(es));
      check($sformatf("r%0d_res_exp", j), 32'(o.exp), 32'(es));
      check($sformatf("r%0d_res_nar", j), 32'(o.nar), 32'(ref_nar()));
      check($sformatf("r%0d_res_timeout", j), 32'(o.to), 32'd0);
      check($sformatf("r%0d_acc_starts", j), 32'(o.starts), 32'(ref_starts()));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
